// File: rtl/uart_rx_fifo_if.sv
// CPU-side read/status port of the UART receiver: pop strobe, head byte and sticky error flags.
interface uart_rx_fifo_if;
    logic       rd_en;
    logic       clr_err;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rx_busy;
    logic       overrun;
    logic       frame_err;

    modport master (
        output rd_en, clr_err,
        input  rd_data, rd_valid, rx_busy, overrun, frame_err
    );

    modport slave (
        input  rd_en, clr_err,
        output rd_data, rd_valid, rx_busy, overrun, frame_err
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a first-word fall-through byte FIFO and sticky overrun/framing flags.
module uart_rx_fifo #(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic [DIV_WIDTH-1:0] divisor,
    uart_rx_fifo_if.slave        bus
);

    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e               state_q, state_d;
    logic                 sync1_q, rxs_q, rxs_prev_q;
    logic [1:0]           flush_q, flush_d;
    logic                 start_edge;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] half;
    logic [2:0]           bitidx_q, bitidx_d;
    logic [7:0]           shift_q, shift_d;
    logic                 push;
    logic                 set_frame_err;

    logic [7:0]           mem_q [FIFO_DEPTH];
    logic [PW-1:0]        wptr_q, wptr_d;
    logic [PW-1:0]        rptr_q, rptr_d;
    logic [PW:0]          count_q, count_d;
    logic                 full, empty, pop, wr_en, set_overrun;
    logic                 overrun_q, overrun_d;
    logic                 frame_err_q, frame_err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
            flush_q    <= '0;
        end else begin
            sync1_q    <= rx;
            rxs_q      <= sync1_q;
            rxs_prev_q <= rxs_q;
            flush_q    <= flush_d;
        end
    end

    // Edges are qualified only once the synchroniser holds real rx history,
    // so a line held low across reset release is not mistaken for a start bit.
    always_comb begin
        flush_d    = (flush_q == 2'd3) ? flush_q : flush_q + 2'd1;
        start_edge = (flush_q == 2'd3) && rxs_prev_q && !rxs_q;
        half       = div_q >> 1;
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q + DIV_WIDTH'(1);
        div_d         = div_q;
        bitidx_d      = bitidx_q;
        shift_d       = shift_q;
        push          = 1'b0;
        set_frame_err = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start_edge) begin
                    state_d = START;
                    cnt_d   = DIV_WIDTH'(1);
                    div_d   = (divisor < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : divisor;
                end
            end
            START: begin
                if (cnt_q == half) begin
                    if (rxs_q) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d  = DATA;
                        cnt_d    = DIV_WIDTH'(1);
                        bitidx_d = '0;
                    end
                end
            end
            DATA: begin
                if (cnt_q == div_q) begin
                    shift_d  = {rxs_q, shift_q[7:1]};
                    cnt_d    = DIV_WIDTH'(1);
                    bitidx_d = bitidx_q + 3'd1;
                    if (bitidx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt_q == div_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (rxs_q) begin
                        push = 1'b1;
                    end else begin
                        set_frame_err = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // A push into a full FIFO still lands when the same cycle pops the head.
    always_comb begin
        full        = (count_q == (PW+1)'(FIFO_DEPTH));
        empty       = (count_q == '0);
        pop         = bus.rd_en && !empty;
        wr_en       = push && (!full || pop);
        set_overrun = push && full && !pop;
        wptr_d      = wr_en ? wptr_q + PW'(1) : wptr_q;
        rptr_d      = pop   ? rptr_q + PW'(1) : rptr_q;
        count_d     = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
        overrun_d   = set_overrun   ? 1'b1 : (bus.clr_err ? 1'b0 : overrun_q);
        frame_err_d = set_frame_err ? 1'b1 : (bus.clr_err ? 1'b0 : frame_err_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            div_q       <= '0;
            bitidx_q    <= '0;
            shift_q     <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            bitidx_q    <= bitidx_d;
            shift_q     <= shift_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wptr_q] <= shift_q;
        end
    end

    assign bus.rd_data   = mem_q[rptr_q];
    assign bus.rd_valid  = !empty;
    assign bus.rx_busy   = (state_q != IDLE);
    assign bus.overrun   = overrun_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed and randomised frames against a queue-based model of the receiver and its FIFO.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic [15:0] divisor;

    uart_rx_fifo_if bus ();

    uart_rx_fifo #(.FIFO_DEPTH(DEPTH), .DIV_WIDTH(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .rx      (rx),
        .divisor (divisor),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    byte unsigned model_q[$];
    logic         model_ovr;
    logic         model_ferr;

    initial begin
        #800000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_frame(input logic [7:0] b, input logic stop);
        if (!stop) model_ferr = 1'b1;
        else if (model_q.size() < DEPTH) model_q.push_back(b);
        else model_ovr = 1'b1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; each bit is held for eff cycles.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int eff, input logic scramble);
        logic [15:0] saved;
        logic [9:0]  fr;
        saved = divisor;
        fr = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rx = fr[k];
            if (scramble && k == 2) divisor = 16'($urandom);
            repeat (eff) @(negedge clk);
        end
        rx = 1'b1;
        divisor = saved;
        model_frame(b, stop);
    endtask

    // Divisor-8 frame driven cycle by cycle; optional pop on edge pop_at.
    task automatic frame8_timed(input logic [7:0] b, input int pop_at, input logic chk_timing);
        logic [9:0] fr;
        logic       popped;
        fr = {1'b1, b, 1'b0};
        popped = 1'b0;
        for (int c = 0; c < 80; c++) begin
            rx = fr[c/8];
            bus.rd_en = (c == pop_at);
            if (c == pop_at) begin
                check("pop_head_valid", bus.rd_valid, 1'b1);
                check("pop_head_data", bus.rd_data, (model_q.size() > 0) ? model_q[0] : 8'h00);
                popped = 1'b1;
            end
            @(posedge clk);
            #1;
            if (chk_timing && c == 1)  check("busy_before_start", bus.rx_busy, 1'b0);
            if (chk_timing && c == 2)  check("busy_after_start", bus.rx_busy, 1'b1);
            if (chk_timing && c == 77) check("valid_at_stop_sample", bus.rd_valid, 1'b0);
            if (chk_timing && c == 78) check("valid_after_stop_sample", bus.rd_valid, 1'b1);
            if (chk_timing && c == 78) check("busy_after_stop", bus.rx_busy, 1'b0);
            @(negedge clk);
        end
        bus.rd_en = 1'b0;
        rx = 1'b1;
        if (popped && model_q.size() > 0) void'(model_q.pop_front());
        model_frame(b, 1'b1);
    endtask

    task automatic pop_check(input string tag);
        byte unsigned exp;
        exp = model_q.pop_front();
        check({tag, "_valid"}, bus.rd_valid, 1'b1);
        check({tag, "_data"}, bus.rd_data, exp);
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
    endtask

    task automatic drain(input string tag);
        while (model_q.size() > 0) pop_check(tag);
        check({tag, "_empty"}, bus.rd_valid, 1'b0);
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_overrun"}, bus.overrun, model_ovr);
        check({tag, "_frame_err"}, bus.frame_err, model_ferr);
    endtask

    task automatic clear_errs();
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
        model_ovr  = 1'b0;
        model_ferr = 1'b0;
    endtask

    initial begin
        int          raw;
        int          eff;
        logic [7:0]  b;
        model_ovr  = 1'b0;
        model_ferr = 1'b0;
        rst = 1'b1;
        rx = 1'b1;
        divisor = 16'd8;
        bus.rd_en = 1'b0;
        bus.clr_err = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", bus.rx_busy, 1'b0);
        check("reset_valid", bus.rd_valid, 1'b0);
        check_flags("reset");
        rst = 1'b0;
        idle(6);

        // Exact latency of a single frame at divisor 8.
        frame8_timed(8'hA5, -1, 1'b1);
        idle(2);
        drain("a5");

        // Back-to-back frames at divisor 104.
        divisor = 16'd104;
        send_frame(8'h00, 1'b1, 104, 1'b0);
        send_frame(8'hFF, 1'b1, 104, 1'b0);
        send_frame(8'h55, 1'b1, 104, 1'b0);
        idle(4);
        drain("b2b");
        check_flags("b2b");

        // Short low glitch is a false start.
        divisor = 16'd8;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        check("glitch_busy", bus.rx_busy, 1'b1);
        idle(20);
        check("glitch_idle", bus.rx_busy, 1'b0);
        check("glitch_valid", bus.rd_valid, 1'b0);
        check_flags("glitch");

        // Stop bit low.
        send_frame(8'h3C, 1'b0, 8, 1'b0);
        idle(4);
        check("ferr_valid", bus.rd_valid, 1'b0);
        check_flags("ferr_set");
        clear_errs();
        check_flags("ferr_clr");

        // Overflow with random bytes, then push+pop while full.
        for (int i = 0; i < DEPTH + 1; i++) send_frame(8'($urandom), 1'b1, 8, 1'b0);
        idle(3);
        check_flags("ovf");
        drain("ovf");
        clear_errs();
        for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom), 1'b1, 8, 1'b0);
        idle(3);
        frame8_timed(8'($urandom), 78, 1'b0);
        idle(3);
        check_flags("full_pushpop");
        drain("full_pushpop");

        // Random divisors (including sub-minimum) with mid-frame divisor changes.
        for (int f = 0; f < 6; f++) begin
            raw = $urandom_range(1, 12);
            eff = (raw < 2) ? 2 : raw;
            divisor = 16'(raw);
            send_frame(8'($urandom), 1'b1, eff, 1'b1);
            idle($urandom_range(2, 5));
        end
        drain("rand_div");
        check_flags("rand_div");

        // Reset in the middle of a data bit, rx low across release.
        divisor = 16'd8;
        send_frame(8'($urandom), 1'b1, 8, 1'b0);
        b = 8'h81;
        rx = 1'b0;
        repeat (8) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            rx = b[k];
            repeat (8) @(negedge clk);
        end
        rx = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_busy", bus.rx_busy, 1'b0);
        check("rst_valid", bus.rd_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        model_q.delete();
        model_ovr  = 1'b0;
        model_ferr = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_low_busy", bus.rx_busy, 1'b0);
        check("rst_low_valid", bus.rd_valid, 1'b0);
        check_flags("rst_low");
        idle(5);
        send_frame(8'h42, 1'b1, 8, 1'b0);
        idle(3);
        drain("post_rst");
        check_flags("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
